// File: rtl/load_unit.sv
// Load unit: fetches one or two aligned memory words for a byte/half/word load,
// then aligns and sign/zero-extends the result before handing it to the consumer.
module load_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_type,
    input  logic        req_unsigned,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_split
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        WAIT0,
        ISSUE1,
        WAIT1,
        RESP
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [1:0]  r_type;
    logic        r_unsigned;
    logic [31:0] r_word0;
    logic [23:0] r_word1;

    logic        w_split;
    logic [31:0] w_base;
    logic [31:0] w_raw;
    logic [31:0] w_result;

    // Only the low three bytes of the second word can ever reach the result.
    always_comb begin
        w_split = ((r_type == 2'b01) && (r_addr[1:0] == 2'b11)) ||
                  (r_type[1] && (r_addr[1:0] != 2'b00));
        w_base  = {r_addr[31:2], 2'b00};
        case (r_addr[1:0])
            2'b00:   w_raw = r_word0;
            2'b01:   w_raw = {r_word1[7:0],  r_word0[31:8]};
            2'b10:   w_raw = {r_word1[15:0], r_word0[31:16]};
            default: w_raw = {r_word1[23:0], r_word0[31:24]};
        endcase
        case (r_type)
            2'b00:   w_result = r_unsigned ? {24'h000000, w_raw[7:0]}
                                           : {{24{w_raw[7]}}, w_raw[7:0]};
            2'b01:   w_result = r_unsigned ? {16'h0000, w_raw[15:0]}
                                           : {{16{w_raw[15]}}, w_raw[15:0]};
            default: w_result = w_raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_type     <= '0;
            r_unsigned <= 1'b0;
            r_word0    <= '0;
            r_word1    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr     <= req_addr;
                        r_type     <= req_type;
                        r_unsigned <= req_unsigned;
                        r_word0    <= '0;
                        r_word1    <= '0;
                        r_state    <= ISSUE0;
                    end
                end
                ISSUE0: r_state <= WAIT0;
                WAIT0: begin
                    if (mem_rd_valid) begin
                        r_word0 <= mem_rdata;
                        r_state <= w_split ? ISSUE1 : RESP;
                    end
                end
                ISSUE1: r_state <= WAIT1;
                WAIT1: begin
                    if (mem_rd_valid) begin
                        r_word1 <= mem_rdata[23:0];
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held, whatever the state register holds.
    always_comb begin
        req_ready = rst_n && (r_state == IDLE);
        mem_rd_en = rst_n && ((r_state == ISSUE0) || (r_state == ISSUE1));
        if (!rst_n) begin
            mem_addr = '0;
        end else if (r_state == ISSUE0) begin
            mem_addr = w_base;
        end else if (r_state == ISSUE1) begin
            mem_addr = w_base + 32'd4;
        end else begin
            mem_addr = '0;
        end
        rsp_valid = rst_n && (r_state == RESP);
        rsp_data  = rsp_valid ? w_result : '0;
        rsp_split = rsp_valid && w_split;
    end

endmodule

// File: tb/tb_load_unit.sv
// Randomized scoreboard bench for load_unit: expectations are computed byte-by-byte
// from a memory image and queued at accept time; monitors compare what the DUT presents.
module tb_load_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_type = '0;
    logic        req_unsigned = 1'b0;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_rd_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_split;

    load_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_type     (req_type),
        .req_unsigned (req_unsigned),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rdata    (mem_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_split    (rsp_split)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        split;
        int          acceptCyc;
        int          expLat;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  typ;
        logic        uns;
        logic [31:0] data;
    } dir_t;

    rsp_t        rspQ[$];
    logic [31:0] addrQ[$];
    bit          headSeen = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          memLatMode = 1;
    bit          spuriousEn = 1'b0;
    bit          rspRandom = 1'b0;
    bit          rspForce = 1'b1;
    bit          memPending = 1'b0;
    int          memDelay = 0;
    logic [31:0] memAddrHeld = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h8899_AABB;
        if (a == 32'h0000_0104) return 32'h1122_3344;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [7:0] memByte(input logic [31:0] a);
        logic [31:0] w;
        w = memWord({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    // Little-endian gather of the requested bytes, then extension from the top loaded bit.
    function automatic void refLoad(input logic [31:0] a, input logic [1:0] t, input logic u,
                                    output logic [31:0] d, output logic s);
        int size;
        size = (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
        d = '0;
        for (int i = 0; i < size; i++) begin
            d = d | ({24'h0, memByte(a + 32'(i))} << (8 * i));
        end
        if (!u && size < 4 && d[8*size-1]) d = d | (32'hFFFF_FFFF << (8 * size));
        s = (int'(a[1:0]) + size) > 4;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] typ, input logic uns,
                                 input bit useConst, input logic [31:0] constData, input bit fixedLat);
        logic [31:0] d;
        logic        s;
        logic [31:0] base;
        int          waitCyc;
        refLoad(addr, typ, uns, d, s);
        if (useConst) d = constData;
        base = {addr[31:2], 2'b00};
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr = addr;
        req_type = typ;
        req_unsigned = uns;
        waitCyc = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waitCyc++;
            if (waitCyc > 200) break;
        end
        if (req_ready) begin
            rspQ.push_back('{d, s, cyc, fixedLat ? (s ? 5 : 3) : -1});
            addrQ.push_back(base);
            if (s) addrQ.push_back(base + 32'd4);
        end else begin
            checkOutput("acceptTimeout", {31'b0, req_ready}, 32'd1);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = $urandom;
        req_type = 2'($urandom_range(0, 3));
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (rspQ.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drainTimeout", rspQ.size(), 32'd0);
    endtask

    // Response monitor: every presented result must match the queue head and stay put until taken.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("resetOutputs", {28'b0, req_ready, mem_rd_en, rsp_valid, rsp_split}, 32'd0);
            checkOutput("resetMemAddr", mem_addr, 32'd0);
            checkOutput("resetRspData", rsp_data, 32'd0);
        end else if (rsp_valid) begin
            checkOutput("readyInResp", {31'b0, req_ready}, 32'd0);
            if (rspQ.size() == 0) begin
                checkOutput("unexpectedRsp", {31'b0, rsp_valid}, 32'd0);
            end else begin
                checkOutput("rspData", rsp_data, rspQ[0].data);
                checkOutput("rspSplit", {31'b0, rsp_split}, {31'b0, rspQ[0].split});
                if (!headSeen) begin
                    headSeen = 1'b1;
                    if (rspQ[0].expLat >= 0)
                        checkOutput("latency", cyc - rspQ[0].acceptCyc, rspQ[0].expLat);
                end
                if (rsp_ready) begin
                    void'(rspQ.pop_front());
                    headSeen = 1'b0;
                end
            end
        end else begin
            checkOutput("idleRsp", rsp_data | {31'b0, rsp_split}, 32'd0);
        end
    end

    // Memory model: returns data after the chosen latency and injects stray valids when nothing is owed.
    always @(negedge clk) begin
        mem_rd_valid = 1'b0;
        mem_rdata = $urandom;
        if (memPending) begin
            memDelay--;
            if (memDelay <= 0) begin
                mem_rd_valid = 1'b1;
                mem_rdata = memWord(memAddrHeld);
                memPending = 1'b0;
            end
        end else if (spuriousEn && $urandom_range(0, 3) == 0) begin
            mem_rd_valid = 1'b1;
        end
        if (rst_n && mem_rd_en) begin
            checkOutput("singleOutstanding", {31'b0, memPending}, 32'd0);
            if (addrQ.size() == 0) begin
                checkOutput("unexpectedRead", {31'b0, mem_rd_en}, 32'd0);
            end else begin
                checkOutput("readAddr", mem_addr, addrQ.pop_front());
            end
            memPending = 1'b1;
            memAddrHeld = mem_addr;
            memDelay = (memLatMode > 0) ? memLatMode : $urandom_range(1, 3);
        end
    end

    always @(posedge clk) begin
        #1;
        rsp_ready = rspRandom ? 1'($urandom_range(0, 1)) : rspForce;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    dir_t dirTab[8];

    initial begin
        dirTab[0] = '{32'h0000_0101, 2'b00, 1'b0, 32'hFFFF_FFAA};
        dirTab[1] = '{32'h0000_0103, 2'b00, 1'b1, 32'h0000_0088};
        dirTab[2] = '{32'h0000_0102, 2'b01, 1'b0, 32'hFFFF_8899};
        dirTab[3] = '{32'h0000_0102, 2'b10, 1'b0, 32'h3344_8899};
        dirTab[4] = '{32'h0000_0103, 2'b01, 1'b0, 32'h0000_4488};
        dirTab[5] = '{32'h0000_0103, 2'b01, 1'b1, 32'h0000_4488};
        dirTab[6] = '{32'h0000_0100, 2'b11, 1'b0, 32'h8899_AABB};
        dirTab[7] = '{32'h0000_0104, 2'b00, 1'b0, 32'h0000_0044};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("readyAfterPowerup", {31'b0, req_ready}, 32'd1);

        $display("[TB] directed loads, 1-cycle memory");
        memLatMode = 1;
        spuriousEn = 1'b1;
        foreach (dirTab[i]) begin
            applyStimulus(dirTab[i].addr, dirTab[i].typ, dirTab[i].uns, 1'b1, dirTab[i].data, 1'b1);
            waitDrain();
        end
        applyStimulus(32'hFFFF_FFFF, 2'b01, 1'b0, 1'b0, 32'h0, 1'b1);
        waitDrain();

        $display("[TB] backpressure");
        rspForce = 1'b0;
        applyStimulus(32'h0000_0102, 2'b10, 1'b0, 1'b1, 32'h3344_8899, 1'b1);
        for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
        repeat (3) begin
            checkOutput("bpValid", {31'b0, rsp_valid}, 32'd1);
            checkOutput("bpReady", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rspForce = 1'b1;
        waitDrain();

        $display("[TB] reset while waiting for data");
        memLatMode = 8;
        applyStimulus(32'h0000_0100, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        rspQ.delete();
        addrQ.delete();
        headSeen = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("readyAfterReset", {31'b0, req_ready}, 32'd1);
        repeat (10) begin
            @(negedge clk);
            checkOutput("noRspAfterReset", {31'b0, rsp_valid}, 32'd0);
        end

        $display("[TB] randomized loads");
        memLatMode = 0;
        rspRandom = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
            applyStimulus(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 32'h0, 1'b0);
        end
        waitDrain();
        rspRandom = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
